key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles needed to accept a press or release (10 ms at 100 MHz); legal range is 2 or more.
REQ-002 Parameter LONG_CYCLES, default 100000000, held cycles after press acceptance before long_pulse fires (1 s at 100 MHz); legal range is greater than DEBOUNCE_CYCLES.
REQ-003 clk  input  1  clock, the same clock as the downstream LED logic (clk_wiz_0 output).
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_n  input  1  raw push-button, asynchronous to clk, active-low.
REQ-006 key_level  output  1  debounced state, 1 = pressed.
REQ-007 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-008 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-009 long_pulse  output  1  one-cycle strobe when a press has lasted LONG_CYCLES.
REQ-010 toggle  output  1  level that inverts on every press_pulse; drives the LED-enable input downstream.

Function
REQ-011 key_n SHALL pass through a 2-flop synchronizer and then be inverted to form key_s (1 = pressed); no other logic SHALL sample key_n.
REQ-012 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-013 IDLE: if key_s=1, go to PRESS_WAIT and clear the debounce counter (dcnt) to 0.
REQ-014 PRESS_WAIT, key_s=0: return to IDLE with no output.
REQ-015 PRESS_WAIT, key_s=1 and dcnt<DEBOUNCE_CYCLES-1: increment dcnt.
REQ-016 PRESS_WAIT, key_s=1 and dcnt=DEBOUNCE_CYCLES-1: go to HELD; register press_pulse=1 for one cycle; set key_level=1; invert toggle; clear the long counter (lcnt) to 0.
REQ-017 HELD: lcnt SHALL increment each cycle and saturate at LONG_CYCLES-1.
REQ-018 HELD: long_pulse SHALL fire once, on the cycle lcnt first reaches LONG_CYCLES-1; it SHALL never repeat within the same press.
REQ-019 HELD: if key_s=0, go to REL_WAIT and clear dcnt; lcnt keeps counting and saturating in REL_WAIT.
REQ-020 REL_WAIT, key_s=1: return to HELD with no output; lcnt and the long_pulse-fired flag are preserved.
REQ-021 REL_WAIT, key_s=0 and dcnt=DEBOUNCE_CYCLES-1: go to IDLE; register release_pulse=1 for one cycle; set key_level=0.
REQ-022 REL_WAIT, key_s=0 and dcnt<DEBOUNCE_CYCLES-1: increment dcnt.
REQ-023 All outputs SHALL be registered; press_pulse, release_pulse and long_pulse SHALL be mutually exclusive in any cycle.
REQ-024 Latency: if key_n is first sampled low at edge N and stays low, press_pulse SHALL be high after edge N+DEBOUNCE_CYCLES+2. Release latency SHALL be the same.
REQ-025 A low glitch on key_n of DEBOUNCE_CYCLES cycles or fewer SHALL produce no pulse and no key_level change; DEBOUNCE_CYCLES+1 cycles SHALL produce a press.
REQ-026 Counter widths SHALL be $clog2 of the respective parameter; counters SHALL never wrap.
REQ-027 If long_pulse and release acceptance would coincide, the REQ-018 and REQ-021 conditions are evaluated independently; long_pulse is generated in the same state-update. If both would fire in the same cycle, release_pulse takes precedence and long_pulse is suppressed for that press.

Reset
REQ-028 While rst=1 at a clock edge:
- sync flops load the released value (1);
- FSM goes to IDLE; dcnt=0, lcnt=0, fired flag=0;
- key_level=0, press_pulse=0, release_pulse=0, long_pulse=0, toggle=0.
REQ-029 Reset asserted mid-press SHALL abort the press silently, with no release_pulse. A key still held after reset deasserts SHALL yield press_pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge at which the sync flops see key_n low.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-030 key_n low from edge 10, held -> press_pulse high after edge 16 only; key_level=1 and toggle=1 from edge 16.
REQ-031 key_n low for 4 cycles, then high -> no pulses; key_level stays 0. Repeat with 5 cycles -> exactly one press_pulse, then one release_pulse.
REQ-032 Hold 40 cycles after press_pulse -> exactly one long_pulse, 19 edges after press_pulse; no second long_pulse.
REQ-033 While HELD, 3-cycle high glitch on key_n -> no release_pulse; key_level stays 1; long_pulse timing unchanged.
REQ-034 rst pulsed for 1 cycle while HELD, key_n kept low -> all outputs 0 at the next edge; no release_pulse; press_pulse re-fires 6 edges after reset deassertion.
REQ-035 Two accepted presses in sequence -> toggle goes 0->1->0; release_pulse follows each press.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop synchronizer feeding a four-state FSM that
// produces a debounced level, press/release/long-press strobes and a toggle.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  logic          r_sync1, r_sync2;
  state_t        r_state, w_state_next;
  logic [DW-1:0] r_dcnt, w_dcnt_next;
  logic [LW-1:0] r_lcnt, w_lcnt_next, w_lcnt_inc;
  logic          r_fired, w_fired_next;
  logic          w_key_s, w_long_hit;
  logic          w_press, w_release, w_long, w_level_next, w_toggle_next;

  assign w_key_s    = ~r_sync2;
  assign w_lcnt_inc = (r_lcnt == L_LAST) ? r_lcnt : r_lcnt + LW'(1);
  // Fires only on the step that lands on the terminal count, once per press.
  assign w_long_hit = !r_fired && (r_lcnt != L_LAST) && (w_lcnt_inc == L_LAST);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_dcnt_next   = r_dcnt;
    w_lcnt_next   = r_lcnt;
    w_fired_next  = r_fired;
    w_press       = 1'b0;
    w_release     = 1'b0;
    w_long        = 1'b0;
    w_level_next  = key_level;
    w_toggle_next = toggle;
    unique case (r_state)
      IDLE: begin
        if (w_key_s) begin
          w_state_next = PRESS_WAIT;
          w_dcnt_next  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_key_s) begin
          w_state_next = IDLE;
        end else if (r_dcnt == D_LAST) begin
          w_state_next  = HELD;
          w_press       = 1'b1;
          w_level_next  = 1'b1;
          w_toggle_next = ~toggle;
          w_lcnt_next   = '0;
          w_fired_next  = 1'b0;
        end else begin
          w_dcnt_next = r_dcnt + DW'(1);
        end
      end
      HELD: begin
        w_lcnt_next = w_lcnt_inc;
        if (w_long_hit) begin
          w_long       = 1'b1;
          w_fired_next = 1'b1;
        end
        if (!w_key_s) begin
          w_state_next = REL_WAIT;
          w_dcnt_next  = '0;
        end
      end
      REL_WAIT: begin
        w_lcnt_next = w_lcnt_inc;
        if (!w_key_s && r_dcnt == D_LAST) begin
          // Release acceptance wins over a coincident long-press strobe.
          w_state_next = IDLE;
          w_release    = 1'b1;
          w_level_next = 1'b0;
        end else begin
          if (w_long_hit) begin
            w_long       = 1'b1;
            w_fired_next = 1'b1;
          end
          if (w_key_s) w_state_next = HELD;
          else         w_dcnt_next  = r_dcnt + DW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= IDLE;
      r_dcnt        <= '0;
      r_lcnt        <= '0;
      r_fired       <= 1'b0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      r_sync1       <= key_n;
      r_sync2       <= r_sync1;
      r_state       <= w_state_next;
      r_dcnt        <= w_dcnt_next;
      r_lcnt        <= w_lcnt_next;
      r_fired       <= w_fired_next;
      key_level     <= w_level_next;
      press_pulse   <= w_press;
      release_pulse <= w_release;
      long_pulse    <= w_long;
      toggle        <= w_toggle_next;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20:
// a per-edge vector table plus hand-written multi-cycle sequences.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  logic key_level, press_pulse, release_pulse, long_pulse, toggle;

  key_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_level(key_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse), .toggle(toggle)
  );

  always #5 clk = ~clk;

  // exp = {key_level, press_pulse, release_pulse, long_pulse, toggle}
  typedef struct {
    logic       rst;
    logic       key_n;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[13];
  int n_cmp = 0, n_bad = 0;
  int cyc, n_press, n_release, n_long, t_press, t_release, t_long, r_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {key_level, press_pulse, release_pulse, long_pulse, toggle};
  endfunction

  task automatic tick(input logic k);
    key_n = k;
    @(posedge clk);
    #1;
    cyc++;
    check("pulse_excl", 32'($countones({press_pulse, release_pulse, long_pulse}) <= 1), 1);
    if (press_pulse)   begin n_press++;   t_press   = cyc; end
    if (release_pulse) begin n_release++; t_release = cyc; end
    if (long_pulse)    begin n_long++;    t_long    = cyc; end
  endtask

  task automatic ticks(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k);
  endtask

  task automatic clear_stats();
    cyc = 0; n_press = 0; n_release = 0; n_long = 0;
    t_press = -1; t_release = -1; t_long = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(1'b1, 2);
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    // Reset, idle, then key held low from vector 4 (edge N): press after N+6.
    for (int i = 0; i < 13; i++) begin
      vecs[i].rst   = (i < 2);
      vecs[i].key_n = (i < 4);
      vecs[i].exp   = 5'b00000;
    end
    vecs[10].exp = 5'b11001;
    vecs[11].exp = 5'b10001;
    vecs[12].exp = 5'b10001;

    for (int i = 0; i < 13; i++) begin
      rst   = vecs[i].rst;
      key_n = vecs[i].key_n;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Low glitch of exactly DEBOUNCE_CYCLES is rejected.
    do_reset();
    ticks(1'b1, 2);
    ticks(1'b0, 4);
    ticks(1'b1, 12);
    check("glitch4_press", n_press, 0);
    check("glitch4_release", n_release, 0);
    check("glitch4_level", 32'(key_level), 0);

    // One cycle longer is accepted; release follows with equal latency.
    clear_stats();
    ticks(1'b0, 5);
    ticks(1'b1, 12);
    check("glitch5_press", n_press, 1);
    check("glitch5_release", n_release, 1);
    check("glitch5_rel_gap", t_release - t_press, 5);
    check("glitch5_level", 32'(key_level), 0);
    check("glitch5_toggle", 32'(toggle), 1);

    // Long hold: exactly one long_pulse, 19 edges after press.
    do_reset();
    ticks(1'b0, 47);
    check("long_press", n_press, 1);
    check("long_count", n_long, 1);
    check("long_delay", t_long - t_press, 19);
    ticks(1'b1, 10);
    check("long_release", n_release, 1);
    check("long_no_repeat", n_long, 1);

    // 3-cycle high glitch while held: no release, long timing unchanged.
    do_reset();
    ticks(1'b0, 10);
    ticks(1'b1, 3);
    ticks(1'b0, 30);
    check("hglitch_release", n_release, 0);
    check("hglitch_level", 32'(key_level), 1);
    check("hglitch_long", n_long, 1);
    check("hglitch_long_delay", t_long - t_press, 19);
    ticks(1'b1, 10);
    check("hglitch_final_rel", n_release, 1);

    // Release acceptance coinciding with long_pulse suppresses long_pulse.
    do_reset();
    ticks(1'b0, 19);
    ticks(1'b1, 12);
    check("coinc_press", n_press, 1);
    check("coinc_release", n_release, 1);
    check("coinc_rel_time", t_release - t_press, 19);
    check("coinc_long", n_long, 0);

    // Reset mid-press: silent abort, press re-fires with full latency.
    do_reset();
    ticks(1'b0, 10);
    check("rstmid_pre_level", 32'(key_level), 1);
    rst = 1'b1;
    tick(1'b0);
    check("rstmid_outs", 32'(outs()), 0);
    rst = 1'b0;
    r_edge = cyc;
    ticks(1'b0, 12);
    check("rstmid_release", n_release, 0);
    check("rstmid_press_cnt", n_press, 2);
    check("rstmid_press_time", t_press, r_edge + 7);

    // Two presses: toggle 0 -> 1 -> 0, each followed by a release.
    do_reset();
    check("tog_init", 32'(toggle), 0);
    ticks(1'b0, 8);
    check("tog_first", 32'(toggle), 1);
    ticks(1'b1, 8);
    check("tog_rel1", n_release, 1);
    ticks(1'b0, 8);
    check("tog_second", 32'(toggle), 0);
    ticks(1'b1, 8);
    check("tog_presses", n_press, 2);
    check("tog_releases", n_release, 2);
    check("tog_final_level", 32'(key_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
